// File: rtl/conv3d_pkg.sv
// Shared constants and state encoding for the 3D convolution core front-end.
// Derived frame sizes are functions so the top can follow its own parameters.
package conv3d_pkg;

  localparam int IMG_W_DEF  = 9;
  localparam int K_DEF      = 3;
  localparam int STRIDE_DEF = 1;
  localparam int DW_DEF     = 8;
  localparam int OW_DEF     = 32;
  localparam int TMO_DEF    = 4095;

  function automatic int npix(input int img_w);
    return img_w * img_w;
  endfunction

  function automatic int ncoef(input int k);
    return k * k;
  endfunction

  function automatic int od(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

  // Two filters, each producing an OD x OD output plane.
  function automatic int nres(input int img_w, input int k, input int stride);
    return 2 * od(img_w, k, stride) * od(img_w, k, stride);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    CLR_IMG,
    LOAD_IMG,
    CLR_FLT,
    LOAD_FLT,
    GO,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/conv3d_stream_reg.sv
// Valid/ready capture stage: accepts a beat while enabled and holds it
// on dout until the next accepted beat; fire marks the accepting cycle.
module conv3d_stream_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         fire,
  output logic [W-1:0] dout
);

  assign ready = en;
  assign fire  = valid && en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (fire) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/conv3d_sequencer.sv
// Front-end sequencer for the 3D convolution core: streams image and filters
// in, drives the core's load/go protocol, then collects and counts results.
module conv3d_sequencer
  import conv3d_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int DW     = DW_DEF,
  parameter int OW     = OW_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [3*DW-1:0] pix_rgb,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [6*DW-1:0] coef_bus,
  output logic          rst_data,
  output logic          ld,
  output logic          lf_0,
  output logic          lf_1,
  output logic          go,
  output logic [DW-1:0] data_in_R,
  output logic [DW-1:0] data_in_G,
  output logic [DW-1:0] data_in_B,
  output logic [DW-1:0] data_in_f0_R,
  output logic [DW-1:0] data_in_f0_G,
  output logic [DW-1:0] data_in_f0_B,
  output logic [DW-1:0] data_in_f1_R,
  output logic [DW-1:0] data_in_f1_G,
  output logic [DW-1:0] data_in_f1_B,
  input  logic          core_done,
  input  logic          core_valid,
  input  logic [OW-1:0] core_out,
  output logic          res_valid,
  output logic [OW-1:0] res_data,
  output logic          frame_done,
  output logic [7:0]    res_count,
  output logic          timeout
);

  localparam int N_PIX  = npix(IMG_W);
  localparam int N_COEF = ncoef(K);
  localparam int N_RES  = nres(IMG_W, K, STRIDE);

  state_t          state_reg, state_next;
  logic [6:0]      pix_cnt_reg;
  logic [3:0]      coef_cnt_reg;
  logic [11:0]     tmo_cnt_reg;
  logic [7:0]      res_cnt_reg, res_cnt_next;
  logic            timeout_reg;
  logic            rst_data_reg, ld_reg, lf_reg, go_reg;
  logic            pix_fire, coef_fire;
  logic            pix_last, coef_last, tmo_hit;
  logic [3*DW-1:0] pix_lanes;
  logic [6*DW-1:0] coef_lanes;

  conv3d_stream_reg #(.W(3*DW)) u_pix (
    .clk   (clk),
    .rst   (reset),
    .en    (state_reg == LOAD_IMG),
    .valid (pix_valid),
    .din   (pix_rgb),
    .ready (pix_ready),
    .fire  (pix_fire),
    .dout  (pix_lanes)
  );

  conv3d_stream_reg #(.W(6*DW)) u_coef (
    .clk   (clk),
    .rst   (reset),
    .en    (state_reg == LOAD_FLT),
    .valid (coef_valid),
    .din   (coef_bus),
    .ready (coef_ready),
    .fire  (coef_fire),
    .dout  (coef_lanes)
  );

  assign pix_last  = pix_fire && (pix_cnt_reg == 7'(N_PIX - 1));
  assign coef_last = coef_fire && (coef_cnt_reg == 4'(N_COEF - 1));
  assign tmo_hit   = (tmo_cnt_reg == 12'(TMO - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = CLR_IMG;
      CLR_IMG:  state_next = LOAD_IMG;
      LOAD_IMG: if (pix_last) state_next = CLR_FLT;
      CLR_FLT:  state_next = LOAD_FLT;
      LOAD_FLT: if (coef_last) state_next = GO;
      GO:       state_next = RUN;
      RUN:      if (core_done || tmo_hit) state_next = FIN;
      FIN:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    res_cnt_next = res_cnt_reg;
    if (state_reg == CLR_IMG) begin
      res_cnt_next = '0;
    end else if (res_valid && res_cnt_reg != 8'hFF) begin
      res_cnt_next = res_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      pix_cnt_reg  <= '0;
      coef_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      res_cnt_reg  <= '0;
      timeout_reg  <= 1'b0;
      rst_data_reg <= 1'b1;
      ld_reg       <= 1'b0;
      lf_reg       <= 1'b0;
      go_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      res_cnt_reg  <= res_cnt_next;
      rst_data_reg <= (state_next == IDLE) || (state_next == CLR_IMG) || (state_next == CLR_FLT);
      ld_reg       <= pix_fire;
      // Held through GO so the core still latches the final coefficient beat.
      lf_reg       <= (state_next == CLR_FLT) || (state_next == LOAD_FLT) || (state_reg == LOAD_FLT);
      go_reg       <= (state_next == GO);

      if (state_reg == CLR_IMG) begin
        pix_cnt_reg <= '0;
      end else if (pix_fire) begin
        pix_cnt_reg <= pix_cnt_reg + 7'd1;
      end

      if (state_reg == CLR_FLT) begin
        coef_cnt_reg <= '0;
      end else if (coef_fire) begin
        coef_cnt_reg <= coef_cnt_reg + 4'd1;
      end

      if (state_reg == GO) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        tmo_cnt_reg <= tmo_cnt_reg + 12'd1;
      end

      // Decided on RUN exit (final count included) so the flag is visible during FIN.
      if (state_reg == IDLE && start) begin
        timeout_reg <= 1'b0;
      end else if (state_reg == RUN && state_next == FIN) begin
        if ((tmo_hit && !core_done) || (res_cnt_next != 8'(N_RES))) begin
          timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == FIN);
  assign res_valid  = core_valid && (state_reg == RUN);
  assign res_data   = res_valid ? core_out : '0;
  assign res_count  = res_cnt_reg;
  assign timeout    = timeout_reg;

  assign rst_data = rst_data_reg;
  assign ld       = ld_reg;
  assign lf_0     = lf_reg;
  assign lf_1     = lf_reg;
  assign go       = go_reg;

  assign data_in_R    = pix_lanes[3*DW-1:2*DW];
  assign data_in_G    = pix_lanes[2*DW-1:DW];
  assign data_in_B    = pix_lanes[DW-1:0];
  assign data_in_f0_R = coef_lanes[6*DW-1:5*DW];
  assign data_in_f0_G = coef_lanes[5*DW-1:4*DW];
  assign data_in_f0_B = coef_lanes[4*DW-1:3*DW];
  assign data_in_f1_R = coef_lanes[3*DW-1:2*DW];
  assign data_in_f1_G = coef_lanes[2*DW-1:DW];
  assign data_in_f1_B = coef_lanes[DW-1:0];

endmodule

// File: tb/tb_conv3d_sequencer.sv
// Directed bench for conv3d_sequencer: table of frame scenarios plus a
// mid-frame reset sequence, with a negedge monitor scoring the core interface.
module tb_conv3d_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        pix_valid, pix_ready;
  logic [23:0] pix_rgb;
  logic        coef_valid, coef_ready;
  logic [47:0] coef_bus;
  logic        rst_data, ld, lf_0, lf_1, go;
  logic [7:0]  data_in_R, data_in_G, data_in_B;
  logic [7:0]  data_in_f0_R, data_in_f0_G, data_in_f0_B;
  logic [7:0]  data_in_f1_R, data_in_f1_G, data_in_f1_B;
  logic        core_done, core_valid;
  logic [31:0] core_out;
  logic        res_valid;
  logic [31:0] res_data;
  logic        frame_done;
  logic [7:0]  res_count;
  logic        timeout;

  always #5 clk = ~clk;

  conv3d_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_bus(coef_bus),
    .rst_data(rst_data), .ld(ld), .lf_0(lf_0), .lf_1(lf_1), .go(go),
    .data_in_R(data_in_R), .data_in_G(data_in_G), .data_in_B(data_in_B),
    .data_in_f0_R(data_in_f0_R), .data_in_f0_G(data_in_f0_G), .data_in_f0_B(data_in_f0_B),
    .data_in_f1_R(data_in_f1_R), .data_in_f1_G(data_in_f1_G), .data_in_f1_B(data_in_f1_B),
    .core_done(core_done), .core_valid(core_valid), .core_out(core_out),
    .res_valid(res_valid), .res_data(res_data), .frame_done(frame_done),
    .res_count(res_count), .timeout(timeout)
  );

  typedef struct {
    int gap;          // drop valid every gap-th cycle (0 = back-to-back)
    int nres;         // results the core model returns
    bit give_done;
    bit done_w_valid; // done coincides with the last valid
    bit start_in_run;
    int exp_count;
    bit exp_tmo;
  } vec_t;

  vec_t vecs[6];
  int total = 0;
  int bad   = 0;

  // monitor state
  int ld_cnt, ld_err, coef_err, coef_upd, rst_lf_cnt, rst_only_cnt;
  int go_cnt, fd_cnt, res_seen, res_err;
  logic [23:0] ld_q[$];
  bit          pix_hs_d, coef_hs_d;
  logic [23:0] pix_d, pix_prev;
  logic [47:0] coef_d, coef_prev;

  function automatic logic [23:0] pix_val(input int i);
    return {8'(i), 8'(i * 3), 8'(200 - i)};
  endfunction

  function automatic logic [47:0] coef_val(input int i);
    return {8'(i + 1), 8'(i + 21), 8'(i + 41), 8'(240 - i), 8'(i * 2 + 3), 8'(i + 101)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    ld_cnt = 0; ld_err = 0; coef_err = 0; coef_upd = 0; rst_lf_cnt = 0;
    rst_only_cnt = 0; go_cnt = 0; fd_cnt = 0; res_seen = 0; res_err = 0;
    ld_q.delete();
  endtask

  always @(negedge clk) begin
    logic [23:0] pl;
    logic [47:0] cl;
    pl = {data_in_R, data_in_G, data_in_B};
    cl = {data_in_f0_R, data_in_f0_G, data_in_f0_B, data_in_f1_R, data_in_f1_G, data_in_f1_B};
    if (reset) begin
      pix_hs_d = 1'b0; coef_hs_d = 1'b0;
      pix_prev = '0;   coef_prev = '0;
    end else begin
      if (ld !== pix_hs_d) ld_err++;
      if (ld) begin ld_cnt++; ld_q.push_back(pl); end
      if (pix_hs_d && pl !== pix_d) ld_err++;
      if (!pix_hs_d && pl !== pix_prev) ld_err++;
      if (coef_hs_d) begin
        if (cl !== coef_d || !lf_0 || !lf_1) coef_err++;
        else coef_upd++;
      end else if (cl !== coef_prev) begin
        coef_err++;
      end
      if (lf_0 !== lf_1) coef_err++;
      if (rst_data && lf_0 && lf_1) rst_lf_cnt++;
      if (rst_data && busy && !lf_0) rst_only_cnt++;
      if (go) go_cnt++;
      if (frame_done) fd_cnt++;
      if (res_valid !== core_valid) res_err++;
      if (res_valid) begin
        res_seen++;
        if (res_data !== core_out) res_err++;
      end
      pix_hs_d  = pix_valid && pix_ready;
      pix_d     = pix_rgb;
      coef_hs_d = coef_valid && coef_ready;
      coef_d    = coef_bus;
      pix_prev  = pl;
      coef_prev = cl;
    end
  end

  // Each send task starts and ends just after a rising edge.
  task automatic send_pixels(input int gap);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < 81 && cyc < 2000) begin
      if (gap != 0 && (cyc % gap) == gap - 1) pix_valid = 1'b0;
      else begin pix_valid = 1'b1; pix_rgb = pix_val(i); end
      @(negedge clk);
      hs = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    pix_valid = 1'b0;
    chk("pix_sent", i, 81);
  endtask

  task automatic send_coefs(input int gap, input int stop_after);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < stop_after && cyc < 2000) begin
      if (gap != 0 && (cyc % gap) == gap - 1) coef_valid = 1'b0;
      else begin coef_valid = 1'b1; coef_bus = coef_val(i); end
      @(negedge clk);
      hs = coef_valid && coef_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    coef_valid = 1'b0;
    chk("coef_sent", i, stop_after);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int cyc;
    bit seen;
    int ord_err;
    clear_mon();
    chk("pre_busy", busy, 0);
    pulse_start();
    chk("clr_busy", busy, 1);
    chk("clr_tmo_cleared", timeout, 0);
    chk("clr_rst_data", rst_data, 1);
    send_pixels(v.gap);
    send_coefs(v.gap, 9);
    seen = 0; cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk); cyc++;
      if (go) seen = 1;
    end
    chk("go_seen", seen, 1);
    if (v.give_done) begin
      @(posedge clk); #1;
      for (int i = 0; i < v.nres; i++) begin
        core_valid = 1'b1;
        core_out   = 32'hC0DE_0000 + 32'(i);
        start      = (v.start_in_run && i == 5);
        if (v.done_w_valid && i == v.nres - 1) core_done = 1'b1;
        @(posedge clk); #1;
      end
      core_valid = 1'b0; start = 1'b0;
      if (!v.done_w_valid) begin
        core_done = 1'b1;
        @(posedge clk); #1;
      end
      core_done = 1'b0;
    end
    seen = 0; cyc = 0;
    while (!seen && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (frame_done) seen = 1;
    end
    chk("fin_seen", seen, 1);
    chk("fin_latency", cyc, v.give_done ? 1 : 4096);
    chk("fin_count", res_count, v.exp_count);
    chk("fin_tmo", timeout, v.exp_tmo);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("fd_pulses", fd_cnt, 1);
    chk("tmo_sticky", timeout, v.exp_tmo);
    chk("ld_pulses", ld_cnt, 81);
    ord_err = 0;
    foreach (ld_q[j]) if (ld_q[j] !== pix_val(j)) ord_err++;
    chk("ld_order", ord_err, 0);
    chk("ld_err", ld_err, 0);
    chk("coef_upd", coef_upd, 9);
    chk("coef_err", coef_err, 0);
    chk("rst_lf_cycles", rst_lf_cnt, 1);
    chk("rst_img_cycles", rst_only_cnt, 1);
    chk("go_cycles", go_cnt, 1);
    chk("res_fwd", res_seen, v.nres);
    chk("res_err", res_err, 0);
    $display("frame %0d: gap=%0d nres=%0d ld=%0d coef_upd=%0d res_count=%0d timeout=%0d",
             idx, v.gap, v.nres, ld_cnt, coef_upd, res_count, timeout);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    pix_valid = 1'b0; pix_rgb = '0;
    coef_valid = 1'b0; coef_bus = '0;
    core_done = 1'b0; core_valid = 1'b0; core_out = '0;

    vecs[0] = '{0,  98, 1'b1, 1'b0, 1'b0,  98, 1'b0};
    vecs[1] = '{3,  98, 1'b1, 1'b0, 1'b0,  98, 1'b0};
    vecs[2] = '{0,  50, 1'b1, 1'b0, 1'b0,  50, 1'b1};
    vecs[3] = '{2,  98, 1'b1, 1'b1, 1'b1,  98, 1'b0};
    vecs[4] = '{0, 300, 1'b1, 1'b0, 1'b0, 255, 1'b1};
    vecs[5] = '{0,   0, 1'b0, 1'b0, 1'b0,   0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rst_data", rst_data, 1);
    chk("rst_ctrl", {ld, lf_0, lf_1, go}, 0);
    chk("rst_host", {busy, pix_ready, coef_ready, res_valid, frame_done, timeout}, 0);
    chk("rst_count", res_count, 0);
    @(negedge clk); #1 reset = 1'b0;

    // Valids while idle must not be taken.
    clear_mon();
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_rgb = 24'hABCDEF;
    coef_valid = 1'b1; coef_bus = 48'h1122_3344_5566;
    repeat (3) @(posedge clk);
    #1 pix_valid = 1'b0; coef_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_ld", ld_cnt + ld_err, 0);
    chk("idle_no_coef", coef_err, 0);
    chk("idle_lanes", |{data_in_R, data_in_G, data_in_B, data_in_f0_R, data_in_f1_B}, 0);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // Reset in LOAD_FLT after four coefficient beats.
    clear_mon();
    pulse_start();
    send_pixels(0);
    send_coefs(0, 4);
    chk("pre_reset_lf", lf_0, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_rst_data", rst_data, 1);
    chk("arst_lf", {lf_0, lf_1}, 0);
    chk("arst_ctrl", {ld, go, busy, coef_ready, timeout}, 0);
    chk("arst_lanes", |{data_in_R, data_in_G, data_in_B, data_in_f0_R, data_in_f0_G,
                        data_in_f0_B, data_in_f1_R, data_in_f1_G, data_in_f1_B}, 0);
    $display("reset in LOAD_FLT: rst_data=%0d lf_0=%0d lf_1=%0d busy=%0d", rst_data, lf_0, lf_1, busy);
    @(negedge clk); #1 reset = 1'b0;

    run_frame(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3d_sequencer.md
Name: conv3d_sequencer

Overview:
- Control front-end for the 3D convolution core (`top`): 9x9 RGB image, two 3x3x3 filters, 32-bit output.
- Accepts the image and filter coefficients over valid/ready streams and generates the core's rst_data/ld/lf_0/lf_1/go protocol.
- Waits for the core's done, counts the out_valid results and reports frame completion, result count or timeout to the host.
- Sits between the host/DMA and the core and replaces the hand-sequenced stimulus used today.

Parameters:
- IMG_W, 9: image width = height, in pixels.
- K, 3: filter width = height.
- STRIDE, 1: convolution stride; must match the core's stride parameter.
- DW, 8: signed pixel/coefficient width.
- OW, 32: core result width.
- TMO, 4095: maximum cycles in RUN before timeout.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a frame; sampled in IDLE only.
- busy, out, 1: high in any state other than IDLE.
- pix_valid, in, 1; pix_ready, out, 1: image stream handshake.
- pix_rgb, in, 3*DW: {R,G,B}, R in the MSBs, raster order.
- coef_valid, in, 1; coef_ready, out, 1: filter stream handshake.
- coef_bus, in, 6*DW: {f0R,f0G,f0B,f1R,f1G,f1B}, f0R in the MSBs.
- rst_data, out, 1; ld, out, 1; lf_0, out, 1; lf_1, out, 1; go, out, 1: core controls.
- data_in_R/G/B, out, DW each: pixel lanes to the core.
- data_in_f0_R/G/B and data_in_f1_R/G/B, out, DW each: coefficient lanes to the core.
- core_done, in, 1; core_valid, in, 1; core_out, in, OW: core status and result.
- res_valid, out, 1; res_data, out, OW: result forwarded to the host.
- frame_done, out, 1: one-cycle pulse at frame end.
- res_count, out, 8: results seen in the current frame.
- timeout, out, 1: sticky error flag.

Behaviour:
- Async reset: state=IDLE, all counters 0, all outputs 0 except rst_data=1. Data lanes reset to 0.
- All core-facing outputs are registered. A stream handshake in cycle n puts its data and ld/lf on the core in cycle n+1.
- Derived constants:
  - NPIX = IMG_W*IMG_W = 81.
  - NCOEF = K*K = 9.
  - OD = (IMG_W-K)/STRIDE+1.
  - NRES = 2*OD*OD = 98 for stride 1.
- IDLE: rst_data=1, busy=0.
  - start -> CLR_IMG.
  - timeout is cleared when start is accepted.
- CLR_IMG: rst_data=1 for one cycle; clears res_count -> LOAD_IMG.
- LOAD_IMG: rst_data=0, pix_ready=1.
  - Each pix_valid&&pix_ready: register pix_rgb onto data_in_R/G/B, ld=1 next cycle, pix_cnt++.
  - With pix_valid=0, ld=0 next cycle (bubble); the core must see no write.
  - On the 81st handshake -> CLR_FLT. The last ld pulse is issued in CLR_FLT's first cycle.
- CLR_FLT: lf_0=lf_1=1 and rst_data=1 for exactly one cycle -> LOAD_FLT.
- LOAD_FLT: rst_data=0, lf_0=lf_1=1 held the whole state, coef_ready=1.
  - Each coef handshake registers the six coefficient lanes, coef_cnt++.
  - Lanes hold their value during stalls.
  - On the 9th handshake -> GO; lf_0/lf_1 drop one cycle after the final lane update.
- GO: go=1 for exactly one cycle -> RUN.
- RUN: core_valid forwarded as res_valid with core_out as res_data, same cycle (combinational path).
  - res_count increments on each core_valid and saturates at 255.
  - core_done -> FIN.
  - A core_valid coinciding with core_done is counted and forwarded.
  - tmo_cnt counts RUN cycles. Reaching TMO sets timeout=1 -> FIN.
- FIN: frame_done=1 for one cycle -> IDLE.
  - If res_count != NRES, timeout is also set.
  - timeout stays sticky until the next start.
- pix_ready is low outside LOAD_IMG and coef_ready is low outside LOAD_FLT. Streams are ignored elsewhere; valid with ready low is not a handshake.
- start while busy is ignored.
- Reset mid-frame returns to IDLE immediately, drops ld/lf/go and asserts rst_data; no partial-frame recovery.
- Unused counter values are unreachable: pix_cnt is 7 bits, coef_cnt 4 bits, tmo_cnt 12 bits.

Decomposition:
- Shared package conv3d_pkg holds:
  - the constants NPIX, NCOEF, OD, NRES (as functions of IMG_W/K/STRIDE);
  - the state enum IDLE, CLR_IMG, LOAD_IMG, CLR_FLT, LOAD_FLT, GO, RUN, FIN.
- One natural sub-module, conv3d_stream_reg: a generic valid/ready-to-write-enable register stage, instantiated for both the pixel and the coefficient paths.
- FSM and counters stay in the top of this block.

Test Plan:
- Nominal frame, stride 1, back-to-back valid, core model returning 98 results then done -> 81 ld pulses, one rst_data pulse with lf high, 9 lf-high coefficient updates, single-cycle go, res_count=98, frame_done pulse, timeout=0.
- Pixel stream with pix_valid low every 3rd cycle -> exactly 81 ld pulses, core sees data in raster order with no duplicates, ld=0 during bubbles.
- Core model asserts done after 50 results -> FIN with res_count=50, timeout=1, busy drops next cycle; next start clears timeout.
- Core model never asserts done, TMO=4095 -> timeout=1 at RUN cycle 4095, frame_done pulse, return to IDLE.
- reset asserted in LOAD_FLT at coef 4 -> outputs at reset values asynchronously (rst_data=1, lf_0=lf_1=0); a new start runs a full clean frame.
- start pulsed during RUN, core_valid coincident with core_done -> start ignored, final result counted and forwarded.
